// File: rtl/seq_fetch_pkg.sv
// Shared constants for the fetch stage and the 12-bit sequencer:
// state encodings, special instruction words and opcode values.
package seq_pkg;

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [11:0] SEQ_WORD_HALT = 12'hFFF;
  localparam logic [11:0] SEQ_WORD_NOP  = 12'h000;

  // Upper nibble of an instruction word selects the sequencer operation.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_ADD  = 4'h2,
    OP_JMP  = 4'h3,
    OP_JZ   = 4'h4,
    OP_OUT  = 4'h5,
    OP_HALT = 4'hF
  } seq_op_e;

  function automatic logic is_halt(input logic [11:0] word);
    return word == SEQ_WORD_HALT;
  endfunction

endpackage

// File: rtl/seq_fetch_if.sv
// Program-load stream and sequencer fetch bus of the fetch stage.
// The slave modport is the fetch stage; the master is the loader/sequencer side.
interface seq_fetch_if;

  logic [11:0] prog_data;
  logic        prog_valid;
  logic        prog_last;
  logic        prog_ready;
  logic [7:0]  next;
  logic [11:0] inst;
  logic        inst_en;

  modport master (
    output prog_data, prog_valid, prog_last, next,
    input  prog_ready, inst, inst_en
  );

  modport slave (
    input  prog_data, prog_valid, prog_last, next,
    output prog_ready, inst, inst_en
  );

endinterface

// File: rtl/seq_fetch_mem.sv
// DEPTH x 12 single-port program RAM, synchronous write and synchronous read.
// No reset: contents and read register power up undefined.
module seq_fetch_mem
  import seq_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  addr,
  input  logic [11:0] wdata,
  output logic [11:0] rdata
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [11:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  // Addresses beyond DEPTH alias here; the caller masks those reads to NOP.
  assign idx = addr[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/seq_fetch.sv
// Instruction fetch stage: loads program memory over a valid/ready stream,
// then fetches/issues one word every two cycles until a HALT word.
// Optional single-step input enabled by defining SEQ_FETCH_STEP_EN.
module seq_fetch
  import seq_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  seq_fetch_if.slave  bus,
  input  logic        reload,
  input  logic        run,
`ifdef SEQ_FETCH_STEP_EN
  input  logic        step,
`endif
  output logic [8:0]  count,
  output logic        loaded,
  output logic        halted
);

  localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);

  logic [2:0]  state;
  logic        in_range_q;
  logic        start;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [11:0] rd_data;

`ifdef SEQ_FETCH_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // Writes only happen in Load and reads only in Fetch, so one port suffices.
  assign mem_we   = (state == ST_LOAD) && bus.prog_valid;
  assign mem_re   = (state == ST_FETCH);
  assign mem_addr = mem_we ? count[7:0] : bus.next;

  seq_fetch_mem #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (bus.prog_data),
    .rdata (rd_data)
  );

  // The range flag is registered alongside the RAM read; it also forces inst
  // to NOP out of reset, since the RAM read register has no reset.
  assign bus.inst       = in_range_q ? rd_data : SEQ_WORD_NOP;
  assign bus.inst_en    = (state == ST_ISSUE) && !is_halt(bus.inst);
  assign bus.prog_ready = (state == ST_LOAD);
  assign halted         = (state == ST_HALT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      count      <= '0;
      loaded     <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.prog_valid) begin
            count <= count + 9'd1;
            if (bus.prog_last || (count == LAST_ADDR)) begin
              state  <= ST_IDLE;
              loaded <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (reload) begin
            state  <= ST_LOAD;
            count  <= '0;
            loaded <= 1'b0;
          end else if (start) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          in_range_q <= ({1'b0, bus.next} < count);
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (is_halt(bus.inst)) begin
            state <= ST_HALT;
          end else if (run) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (reload) begin
            state  <= ST_LOAD;
            count  <= '0;
            loaded <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: doc/seq_fetch.md
# seq_fetch

Instruction fetch stage feeding the 12-bit sequencer. It holds a program memory that is loaded once over a valid/ready stream. It then fetches the word at the sequencer's `next` address and presents it on `inst`/`inst_en`, issuing one instruction every two cycles. It also detects a HALT word and stops issuing when it sees it.

## Interface
- `DEPTH`, 256: program words, 1..256; word addresses 0..DEPTH-1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `prog_data`  in  12  program word to load.
- `prog_valid`  in  1  `prog_data` is valid.
- `prog_last`  in  1  qualifies the final word of the program.
- `prog_ready`  out  1  high only in the Load state.
- `reload`  in  1  one-cycle pulse; returns the block to Load.
- `run`  in  1  level; enables continuous fetch/issue.
- `next`  in  8  address from the sequencer; stable except after an `inst_en` cycle.
- `inst`  out  12  fetched instruction word (register).
- `inst_en`  out  1  `inst` is valid this cycle; sequencer consumes it.
- `count`  out  9  number of words loaded, 0..DEPTH.
- `loaded`  out  1  high once a load has completed; cleared by reset and by `reload`.
- `halted`  out  1  high in the Halt state.

## Operation
- States: Load, Idle, Fetch, Issue, Halt.
- Reset sets state Load, `count`=0, `inst`=0, `loaded`=0.
- Reset values of the outputs:
  - `prog_ready`=1 (decoded from Load).
  - `inst_en`=0, `halted`=0.
- Load:
  - A transfer occurs when `prog_valid`&&`prog_ready`; it writes mem[`count`]=`prog_data` and increments `count`.
  - The load ends when the transferred word has `prog_last`=1, or when it is the word at address DEPTH-1. The block then moves to Idle with `loaded`=1.
  - `prog_valid`=0 holds the block in Load.
- Idle:
  - `run`=1 moves to Fetch.
  - `reload` sets `count`=0, `loaded`=0 and moves to Load. `reload` takes priority over `run`.
- Fetch:
  - Sets `inst` <= (`next` < `count`) ? mem[`next`] : 12'h000 (NOP).
  - Always moves to Issue.
- Issue:
  - If `inst`==12'hFFF (HALT): `inst_en`=0 and move to Halt.
  - Otherwise `inst_en`=1 for exactly this cycle. The block then moves to Fetch if `run`=1, else to Idle.
- Halt:
  - `halted`=1.
  - Only `reload` or `reset` exits it; `reload` sets `count`=0, `loaded`=0 and moves to Load.
- Boundary rules:
  - `reload` is ignored in Fetch and Issue.
  - `prog_*` inputs are ignored outside Load.
  - `run` falling during Fetch still completes the Issue.
  - `next` values of 128..255 compare unsigned against `count`.
  - Reset mid-load: memory contents are kept but unreachable, because `count`=0 makes every read return NOP.

## Timing
- Load throughput: one word per cycle.
- The transition to Idle occurs on the edge that accepts the last word; `prog_ready` is low the following cycle.
- Fetch latency: `next` is sampled in Fetch, and `inst`/`inst_en` are valid in the next cycle (Issue).
- Issue rate: one instruction per 2 cycles.
- The sequencer updates `next` on the Issue edge, so the following Fetch sees the new address.
- `inst_en` is decoded from the state and `inst` registers only; there is no combinational path from any input.
- `halted` rises the cycle after the Issue that saw HALT.

## Configuration
- `SEQ_FETCH_STEP_EN` defined:
  - Adds port `step`, in, 1.
  - In Idle, a one-cycle `step` pulse with `run`=0 performs exactly one Fetch→Issue and then returns to Idle.
  - `reload` takes priority over `step`; `step` is ignored outside Idle.
- `SEQ_FETCH_STEP_EN` undefined: there is no `step` port, and only `run` starts fetching.

## Structure
- `seq_pkg` holds:
  - the state encodings (3 bits);
  - `SEQ_WORD_HALT`=12'hFFF and `SEQ_WORD_NOP`=12'h000;
  - the opcode constants shared with the sequencer.
- Sub-module `seq_fetch_mem` is a DEPTH×12 single-port RAM with synchronous write and synchronous read into `inst`. It has no reset.
- The FSM, `count`, and the range compare stay in `seq_fetch`.

## Test plan
- Load and halt:
  - Stimulus: reset, then stream 12'h105, 12'h301, 12'hFFF with `prog_last` on the third word.
  - Required: `count`=3, `loaded`=1, and `prog_ready` low the next cycle.
  - Then with `run`=1 and `next` following 0,1,2: `inst`=12'h105 and 12'h301 each appear with a single-cycle `inst_en`, 2 cycles apart. `inst_en` stays 0 for 12'hFFF, and `halted`=1.
- Backpressure: toggle `prog_valid` 1,0,1,0 with `prog_last` on the 2nd valid word → `count` goes 1,1,2 and Load exits only after the 2nd word.
- Out-of-range read: with `count`=3, drive `next`=8'd200 → Issue presents `inst`=12'h000 with `inst_en`=1.
- Full memory: with DEPTH=4, stream 6 words and no `prog_last` → exactly 4 words accepted, `count`=4, `prog_ready`=0 from the 5th cycle.
- Reset and reload:
  - Assert `reset` after 2 loaded words → `count`=0, all outputs at reset values; a fetch then returns NOP.
  - `reload` from Halt → Load with `count`=0 and `loaded`=0.
- `SEQ_FETCH_STEP_EN` defined: in Idle with `run`=0, pulse `step` twice → exactly two `inst_en` pulses and the state returns to Idle each time.
